// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock-enable generator (optional CLKDIV_SYNC_EN phase-restart input)
module clkdiv_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);
  logic sync_w;
`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d, pend_q, pend_d, cnt_q, cnt_d;
    logic             pv_q, pv_d, co_q, co_d, tk_q, tk_d, hit, wrap, bound;
    // Out-of-range channel numbers never match any g, so they are ignored.
    assign hit   = cfg_we && (cfg_ch == CH_W'(g));
    assign wrap  = (div_q <= DIV_W'(1)) || (cnt_q == div_q - 1'b1);
    assign bound = sync_w || wrap;
    always_comb begin
      div_d  = (bound && (hit || pv_q)) ? (hit ? cfg_div : pend_q) : div_q;
      pend_d = hit ? cfg_div : pend_q;
      pv_d   = !bound && (hit || pv_q);
      cnt_d  = bound ? '0 : cnt_q + 1'b1;
      co_d   = !sync_w && ((div_q == DIV_W'(1)) || (cnt_q < (div_q >> 1)));
      tk_d   = !sync_w && (div_q != '0) && wrap;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        div_q  <= DIV_W'(DEFAULT_DIV);
        pend_q <= '0;
        cnt_q  <= '0;
        pv_q   <= 1'b0;
        co_q   <= 1'b0;
        tk_q   <= 1'b0;
      end else begin
        div_q  <= div_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
        pv_q   <= pv_d;
        co_q   <= co_d;
        tk_q   <= tk_d;
      end
    end
    assign clk_out[g] = co_q;
    assign tick[g]    = tk_q;
    assign pending[g] = pv_q;
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: scoreboard bench for clkdiv_multi (4-channel and 3-channel instances)
module tb_clkdiv_multi;
  logic clk = 0, rst = 1, cfg_we = 0, sync_s = 0, cfg_we3 = 0;
  logic [1:0] cfg_ch = 0, cfg_ch3 = 0;
  logic [7:0] cfg_div = 0, cfg_div3 = 0;
  logic [3:0] clk_out, tick, pending;
  logic [2:0] clk_out3, tick3, pending3;
  int checks = 0, failures = 0;
  string tname = "";
  typedef struct {logic [3:0] co, tk, pd; logic [2:0] co3, tk3, pd3;} exp_t;
  exp_t q[$];
  int mdiv[4], mcnt[4], mpdiv[4], ph3;
  bit mpv[4];

  always #5 clk = ~clk;

  clkdiv_multi dut (.clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLKDIV_SYNC_EN
    .sync(sync_s),
`endif
    .clk_out(clk_out), .tick(tick), .pending(pending));

  clkdiv_multi #(.CHANNELS(3)) dut3 (.clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
`ifdef CLKDIV_SYNC_EN
    .sync(sync_s),
`endif
    .clk_out(clk_out3), .tick(tick3), .pending(pending3));

  task automatic cycle(input bit r, input bit we, input int ch, input int dv, input bit sy);
    exp_t e, o;
    bit hit, wrap;
    rst = r; cfg_we = we; cfg_ch = 2'(ch); cfg_div = 8'(dv); sync_s = sy;
    for (int c = 0; c < 4; c++) begin
      hit = we && (ch == c);
      if (r) begin
        mdiv[c] = 2; mcnt[c] = 0; mpv[c] = 0; mpdiv[c] = 0;
        e.co[c] = 0; e.tk[c] = 0;
      end else if (sy) begin
        e.co[c] = 0; e.tk[c] = 0;
        if (hit) mdiv[c] = dv; else if (mpv[c]) mdiv[c] = mpdiv[c];
        mcnt[c] = 0; mpv[c] = 0;
      end else begin
        wrap = (mdiv[c] <= 1) || (mcnt[c] == mdiv[c] - 1);
        e.co[c] = (mdiv[c] == 0) ? 0 : (mdiv[c] == 1) ? 1 : (mcnt[c] < mdiv[c] / 2);
        e.tk[c] = (mdiv[c] != 0) && wrap;
        if (wrap) begin
          mcnt[c] = 0;
          if (hit) begin mdiv[c] = dv; mpv[c] = 0; end
          else if (mpv[c]) begin mdiv[c] = mpdiv[c]; mpv[c] = 0; end
        end else begin
          mcnt[c]++;
          if (hit) begin mpdiv[c] = dv; mpv[c] = 1; end
        end
      end
      e.pd[c] = mpv[c];
    end
    // dut3 only ever receives writes to its non-existent channel 3, so it stays at divide-by-2.
    e.co3 = (r || sy) ? 3'b000 : (ph3 == 0) ? 3'b111 : 3'b000;
    e.tk3 = (r || sy) ? 3'b000 : (ph3 == 1) ? 3'b111 : 3'b000;
    e.pd3 = 3'b000;
    ph3 = (r || sy) ? 0 : (ph3 + 1) % 2;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== {o.co, o.tk, o.pd}) begin
      failures++;
      $display("FAIL %s: clk_out/tick/pending got %b/%b/%b expected %b/%b/%b", tname, clk_out, tick, pending, o.co, o.tk, o.pd);
    end
    checks++;
    if ({clk_out3, tick3, pending3} !== {o.co3, o.tk3, o.pd3}) begin
      failures++;
      $display("FAIL %s: ch3 clk_out/tick/pending got %b/%b/%b expected %b/%b/%b", tname, clk_out3, tick3, pending3, o.co3, o.tk3, o.pd3);
    end
    cfg_we = 0; sync_s = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    tname = "reset";
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (clk_out !== 4'h0 || tick !== 4'h0 || pending !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: got %b/%b/%b expected 0000/0000/0000", clk_out, tick, pending);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (clk_out !== 4'hF || tick !== 4'h0) begin
      failures++;
      $display("FAIL first_edge: clk_out/tick got %b/%b expected 1111/0000", clk_out, tick);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (clk_out !== 4'h0 || tick !== 4'hF) begin
      failures++;
      $display("FAIL second_edge: clk_out/tick got %b/%b expected 0000/1111", clk_out, tick);
    end
    idle(4);
  endtask

  task automatic test_div5();
    tname = "div5";
    cycle(0, 1, 1, 5, 0);
    checks++;
    if (pending !== 4'b0010) begin
      failures++;
      $display("FAIL div5_pending: got %b expected 0010", pending);
    end
    idle(16);
  endtask

  task automatic test_stop();
    tname = "stop";
    cycle(0, 1, 2, 0, 0);
    idle(5);
    checks++;
    if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
      failures++;
      $display("FAIL stopped: ch2 clk_out/tick got %b/%b expected 0/0", clk_out[2], tick[2]);
    end
    cycle(0, 1, 2, 3, 0);
    idle(10);
  endtask

  task automatic test_last_wins();
    tname = "last_wins";
    cycle(0, 1, 0, 9, 0);
    idle(12);
    cycle(0, 1, 0, 7, 0);
    cycle(0, 1, 0, 4, 0);
    idle(16);
  endtask

  task automatic test_bad_ch();
    tname = "bad_ch";
    cfg_we3 = 1; cfg_ch3 = 2'd3; cfg_div3 = 8'd5;
    cycle(0, 0, 0, 0, 0);
    cfg_we3 = 0;
    checks++;
    if (pending3 !== 3'b000) begin
      failures++;
      $display("FAIL bad_ch_pending: got %b expected 000", pending3);
    end
    idle(6);
  endtask

  task automatic test_back_to_back();
    tname = "back_to_back";
    for (int i = 0; i < 300; i++) begin
      cfg_we3 = ($urandom_range(0, 4) == 0); cfg_ch3 = 2'd3; cfg_div3 = 8'($urandom_range(0, 9));
      cycle(0, $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 9), 0);
    end
    cfg_we3 = 0;
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    tname = "sync";
    cycle(0, 1, 0, 3, 0);
    idle(2);
    cycle(0, 1, 1, 4, 0);
    idle(3);
    cycle(0, 1, 2, 6, 0);
    cycle(0, 1, 3, 2, 0);
    idle(13);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (clk_out !== 4'h0 || tick !== 4'h0) begin
      failures++;
      $display("FAIL sync_edge: clk_out/tick got %b/%b expected 0000/0000", clk_out, tick);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (clk_out[2:0] !== 3'b111) begin
      failures++;
      $display("FAIL sync_rise: clk_out[2:0] got %b expected 111", clk_out[2:0]);
    end
    idle(26);
  endtask
`endif

  initial begin
    test_reset();
    test_div5();
    test_stop();
    test_last_wins();
    test_bad_ch();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
